// File: rtl/ex_div_unit_if.sv
// EX-stage divide request/response bundle between EX decode (master) and the divider (slave).
interface ex_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             annul;
  logic             stallreq;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  stallreq, ready, quotient, remainder
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output stallreq, ready, quotient, remainder
  );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls the pipeline while busy
// and presents registered quotient (LO) / remainder (HI) in its END cycle.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   work;
  logic [2*WIDTH:0]   shifted;
  logic [2*WIDTH:0]   work_step;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   dvs_mag;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   quo_r, rem_r;
  logic [WIDTH-1:0]   dvd_abs, dvs_abs, q_fix, r_fix;
  logic               accept, last_step;

  assign accept    = (state == S_IDLE) && bus.start && !bus.annul;
  assign last_step = (state == S_ON) && (cnt == CW'(WIDTH - 1));

  assign dvd_abs = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dvs_abs = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // One restoring step: upper WIDTH+1 bits hold the partial remainder, lower bits collect quotient.
  always_comb begin
    shifted   = {work[2*WIDTH-1:0], 1'b0};
    trial     = shifted[2*WIDTH:WIDTH] - {1'b0, dvs_mag};
    work_step = shifted;
    if (!trial[WIDTH]) begin
      work_step = {trial, shifted[WIDTH-1:1], 1'b1};
    end
  end

  assign q_fix = neg_q ? -work_step[WIDTH-1:0] : work_step[WIDTH-1:0];
  assign r_fix = neg_r ? -work_step[2*WIDTH-1:WIDTH] : work_step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (bus.divisor == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: state_nxt = S_END;
      S_ON: begin
        if (last_step) begin
          state_nxt = S_END;
        end
      end
      S_END: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.annul) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      work    <= '0;
      dvs_mag <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        neg_q   <= bus.signed_div && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        neg_r   <= bus.signed_div && bus.dividend[WIDTH-1];
        dvs_mag <= dvs_abs;
        work    <= {{(WIDTH+1){1'b0}}, dvd_abs};
        cnt     <= '0;
      end else if (state == S_ON && !bus.annul) begin
        work <= work_step;
        cnt  <= cnt + CW'(1);
      end
      // A flush leaves the previously delivered HI/LO untouched.
      if (!bus.annul) begin
        if (last_step) begin
          quo_r <= q_fix;
          rem_r <= r_fix;
        end else if (state == S_DIVZERO) begin
          quo_r <= '0;
          rem_r <= '0;
        end
      end
    end
  end

  assign bus.stallreq  = accept || (state == S_DIVZERO) || (state == S_ON);
  assign bus.ready     = (state == S_END);
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: driver pushes model results, monitor checks on ready.
module tb_ex_div_unit;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  logic [W-1:0] last_q, last_r;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;
  exp_t sb[$];

  ex_div_unit_if #(.WIDTH(W)) bus ();

  ex_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes dividend's sign.
  function automatic void model(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb_;
    if (b == 0) begin
      q = '0;
      r = '0;
    end else if (sd) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
      q   = W'(sa / sb_);
      r   = W'(sa % sb_);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: independent of the driver, compares every ready pulse with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(bus.ready), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("quotient", 64'(bus.quotient), 64'(e.q));
          chk("remainder", 64'(bus.remainder), 64'(e.r));
          chk("ready_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic run_op(input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   found;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.dividend   = a;
    bus.divisor    = b;
    model(sd, a, b, e.q, e.r);
    e.due = cyc + ((b == 0) ? 2 : W + 1);
    sb.push_back(e);
    #1 chk("stall_accept", 64'(bus.stallreq), 64'(1));
    @(negedge clk);
    bus.start      = 1'b0;
    bus.signed_div = 1'($urandom);
    bus.dividend   = $urandom;
    bus.divisor    = $urandom;
    found = 0;
    for (int i = 0; i < W + 8 && !found; i++) begin
      #1;
      if (bus.ready) begin
        found = 1;
        chk("stall_end", 64'(bus.stallreq), 64'(0));
      end else begin
        chk("stall_busy", 64'(bus.stallreq), 64'(1));
        @(negedge clk);
      end
    end
    if (!found) chk("ready_timeout", 64'(0), 64'(1));
    last_q = e.q;
    last_r = e.r;
  endtask

  initial begin
    int nready;
    bit sd;
    logic [W-1:0] a, b;
    cyc            = 0;
    tests          = 0;
    fails          = 0;
    last_q         = '0;
    last_r         = '0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.annul      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'(0));
    chk("rst_stall", 64'(bus.stallreq), 64'(0));
    chk("rst_quot", 64'(bus.quotient), 64'(0));
    chk("rst_rem", 64'(bus.remainder), 64'(0));
    rst_n = 1'b1;

    run_op(0, 32'd100, 32'd7);
    run_op(1, 32'hFFFF_FFF9, 32'd2);
    run_op(1, 32'd7, 32'hFFFF_FFFE);
    run_op(0, 32'h1234, 32'd0);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Cancellation mid-divide: unit idles, keeps old outputs, never pulses ready.
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    #1;
    chk("annul_stall", 64'(bus.stallreq), 64'(0));
    chk("annul_ready", 64'(bus.ready), 64'(0));
    chk("annul_quot_held", 64'(bus.quotient), 64'(last_q));
    chk("annul_rem_held", 64'(bus.remainder), 64'(last_r));
    run_op(0, 32'd9, 32'd3);

    // Simultaneous start and annul in IDLE accepts nothing.
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    #1 chk("start_annul_stall", 64'(bus.stallreq), 64'(0));
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    nready = 0;
    for (int i = 0; i < W + 4; i++) begin
      #1;
      if (bus.ready) nready++;
      chk("start_annul_idle", 64'(bus.stallreq), 64'(0));
      @(negedge clk);
    end
    chk("start_annul_no_ready", 64'(nready), 64'(0));

    for (int n = 0; n < 40; n++) begin
      sd = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        3:       b = $urandom;
        default: b = a >> $urandom_range(0, 8);
      endcase
      if (n == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sd = 1'b1; end
      run_op(sd, a, b);
    end

    // Asynchronous reset mid-operation clears outputs at once.
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 64'(bus.ready), 64'(0));
    chk("async_rst_stall", 64'(bus.stallreq), 64'(0));
    chk("async_rst_quot", 64'(bus.quotient), 64'(0));
    chk("async_rst_rem", 64'(bus.remainder), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'hFFFF_FFFF, 32'h10);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative radix-2 divide unit in the EX stage. It executes DIV/DIVU over WIDTH+2 cycles and holds the pipeline through a stall request while it runs. Its quotient and remainder are packed by EX onto the EX-to-MEM bus as the HI/LO write data, so MEM receives a finished result in the cycle the stall releases. It has one FSM with a shift-subtract datapath, and it can be cancelled by a pipeline flush.

## Interface
- WIDTH, 32, operand/result width in bits; the iteration counter is $clog2(WIDTH)+1 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low. It clears all state immediately on assertion.
- start  in  1  divide request from EX decode. Sampled only in IDLE; level-held by EX while stalled.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- dividend  in  WIDTH  rs operand. Sampled with start.
- divisor  in  WIDTH  rt operand. Sampled with start.
- annul  in  1  flush/cancel. Highest priority after reset.
- stallreq  out  1  request to hold IF/ID/EX (feeds stall bus bit for EX).
- ready  out  1  result valid; high for exactly one cycle per completed operation.
- quotient  out  WIDTH  LO value; registered, held until the next accepted start.
- remainder  out  WIDTH  HI value; registered, held until the next accepted start.

## Operation
- States are IDLE, DIVZERO, ON and END. Reset state is IDLE.
- IDLE behaviour:
  - start=1 with annul=0 accepts the operation. The unit latches signed_div and the operand magnitudes; when signed_div=1, each negative operand is negated.
  - The next state is DIVZERO if divisor==0; otherwise the next state is ON with the counter cleared.
- ON performs one restoring step per cycle. The working register is 2·WIDTH+1 bits, initialised to {WIDTH+1 zeros, |dividend|}. Each step:
  - Shift left by one.
  - Trial-subtract |divisor| from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set bit 0 to 1; otherwise restore and set bit 0 to 0.
  - The counter increments each step. After WIDTH steps the next state is END.
- Sign fix-up happens on the transition into END:
  - quotient is negated if signed_div and sign(dividend)≠sign(divisor).
  - remainder is negated if signed_div and the dividend is negative.
  - Both are written to the output registers.
- DIVZERO loads quotient=0 and remainder=0, then goes to END.
- END drives ready=1 and goes to IDLE unconditionally. A start seen in END is ignored.
- annul=1 in any state forces IDLE on the next edge. In that case ready stays 0 and quotient/remainder keep their previous values.
- start outside IDLE is ignored. Operands may change freely after acceptance.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap.

## Timing
- Reset values: stallreq=0, ready=0, quotient=0, remainder=0, state=IDLE, counter=0.
- stallreq is combinational and equals (IDLE & start & ~annul) | DIVZERO | ON. It is 0 in END, so EX advances and hands the result to MEM in that same cycle.
- ready is Moore (END only). quotient/remainder are stable from the END cycle onward.
- Latency, with start accepted at cycle 0:
  - Normal divide: ON in cycles 1..WIDTH, END (ready=1) at cycle WIDTH+1, which is 33 for WIDTH=32.
  - Divide by zero: DIVZERO at cycle 1, END at cycle 2.
- Back-to-back operation: the earliest next acceptance is the cycle after END (IDLE). The minimum issue interval is WIDTH+2 cycles.
- Simultaneous start and annul in IDLE: nothing is accepted and stallreq=0.
- Reset asserted mid-operation returns the unit to IDLE and clears all outputs asynchronously. After release, it accepts a start on the first clock edge.

## Test plan
- DIVU 100 / 7, start at cycle 0: stallreq=1 for cycles 0..32, ready=1 at cycle 33 only, quotient=14, remainder=2.
- DIV 0xFFFFFFF9 (−7) / 2: ready at cycle 33, quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also DIV 7 / 0xFFFFFFFE: quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, DIVU 0x1234 / 0: ready at cycle 2, quotient=0, remainder=0, stallreq low from cycle 2.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: ready at cycle 33, quotient=0x80000000, remainder=0.
- Cancellation: start 100/7 at cycle 0, annul at cycle 10. Expect state IDLE at cycle 11, stallreq=0, no ready pulse, and outputs unchanged. Then start 9/3 at cycle 12 gives ready at cycle 45 with quotient=3, remainder=0.
- Reset: pull rst low at cycle 5 of an operation. Expect outputs to go to 0 immediately and no ready pulse. Then DIVU 0xFFFFFFFF / 0x10 after release gives quotient=0x0FFFFFFF, remainder=0xF.
